ntt_bram_arbiter: RTL and testbench

- Shares the single 64-bit NTT BRAM port between two requesters: port 0 (host loader/unloader) and port 1 (NTT engine sequencer).
- Round-robin arbitration; one access issued per cycle; pipelined reads with fixed BRAM read latency.
- Each read return is routed back to its issuer by tag.
- Sits between the requesters and the BRAM_* pins.

---
 rtl/ntt_bram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ntt_bram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bram_arbiter.sv
// Round-robin arbiter sharing the single NTT BRAM port between the host (port 0) and the NTT sequencer (port 1).
// Optional feature macro ARB_LOCK_EN: the port accepted last cycle may hold the grant with mX_lock.
module ntt_bram_arbiter #(
  parameter int unsigned AW     = 13,
  parameter int unsigned DW     = 64,
  parameter int unsigned RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] BRAM_addr,
  output logic          BRAM_clk,
  output logic [DW-1:0] BRAM_din,
  input  logic [DW-1:0] BRAM_dout,
  output logic          BRAM_en,
  output logic          BRAM_we,
  output logic          busy
);

  // Tag stage 0 is the issue cycle; stage RD_LAT lines up with valid BRAM_dout.
  localparam int unsigned TAG_D = RD_LAT + 1;

  logic             last_grant;
  logic             last_grant_nxt;
  logic             lock_hold_c;
  logic             gnt_any_c;
  logic             gnt_port_c;
  logic             sel_we_c;
  logic [AW-1:0]    sel_addr_c;
  logic [DW-1:0]    sel_wdata_c;
  logic [TAG_D-1:0] tag_valid;
  logic [TAG_D-1:0] tag_port;
  logic [TAG_D-1:0] tag_valid_nxt;
  logic [TAG_D-1:0] tag_port_nxt;
  logic             m0_rvalid_nxt;
  logic             m1_rvalid_nxt;

  assign BRAM_clk = clk;

`ifdef ARB_LOCK_EN
  // BRAM_en high means the port in last_grant was accepted in the previous cycle.
  always_comb begin
    lock_hold_c = 1'b0;
    if (BRAM_en) begin
      lock_hold_c = last_grant ? (m1_req & m1_lock) : (m0_req & m0_lock);
    end
  end
`else
  logic unused_lock_c;
  assign unused_lock_c = m0_lock ^ m1_lock;
  assign lock_hold_c   = 1'b0;
`endif

  // Grant selection: lock hold, then round-robin on contention, else the lone requester.
  always_comb begin
    gnt_any_c  = 1'b0;
    gnt_port_c = 1'b0;
    if (!rst) begin
      if (lock_hold_c) begin
        gnt_any_c  = 1'b1;
        gnt_port_c = last_grant;
      end else if (m0_req && m1_req) begin
        gnt_any_c  = 1'b1;
        gnt_port_c = ~last_grant;
      end else if (m0_req) begin
        gnt_any_c  = 1'b1;
        gnt_port_c = 1'b0;
      end else if (m1_req) begin
        gnt_any_c  = 1'b1;
        gnt_port_c = 1'b1;
      end
    end
  end

  assign m0_gnt = gnt_any_c & ~gnt_port_c;
  assign m1_gnt = gnt_any_c & gnt_port_c;

  always_comb begin
    sel_we_c    = m0_we;
    sel_addr_c  = m0_addr;
    sel_wdata_c = m0_wdata;
    if (gnt_port_c) begin
      sel_we_c    = m1_we;
      sel_addr_c  = m1_addr;
      sel_wdata_c = m1_wdata;
    end
  end

  // Arbitration pointer moves only on acceptance.
  always_comb begin
    last_grant_nxt = last_grant;
    if (gnt_any_c) begin
      last_grant_nxt = gnt_port_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // Issue stage: one registered BRAM access per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      BRAM_en   <= 1'b0;
      BRAM_we   <= 1'b0;
      BRAM_addr <= '0;
      BRAM_din  <= '0;
    end else begin
      BRAM_en <= gnt_any_c;
      BRAM_we <= gnt_any_c & sel_we_c;
      if (gnt_any_c) begin
        BRAM_addr <= sel_addr_c;
        BRAM_din  <= sel_wdata_c;
      end
    end
  end

  // Read tag pipeline: {valid, port} travels alongside the BRAM latency.
  always_comb begin
    tag_valid_nxt    = '0;
    tag_port_nxt     = '0;
    tag_valid_nxt[0] = gnt_any_c & ~sel_we_c;
    tag_port_nxt[0]  = gnt_port_c;
    for (int i = 1; i < int'(TAG_D); i++) begin
      tag_valid_nxt[i] = tag_valid[i-1];
      tag_port_nxt[i]  = tag_port[i-1];
    end
    m0_rvalid_nxt = tag_valid[TAG_D-1] & ~tag_port[TAG_D-1];
    m1_rvalid_nxt = tag_valid[TAG_D-1] & tag_port[TAG_D-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid <= tag_valid_nxt;
      tag_port  <= tag_port_nxt;
    end
  end

  // Return stage: route BRAM_dout to the issuing port; rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      m0_rvalid <= m0_rvalid_nxt;
      m1_rvalid <= m1_rvalid_nxt;
      if (m0_rvalid_nxt) begin
        m0_rdata <= BRAM_dout;
      end
      if (m1_rvalid_nxt) begin
        m1_rdata <= BRAM_dout;
      end
      busy <= (|tag_valid_nxt) | m0_rvalid_nxt | m1_rvalid_nxt;
    end
  end

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Self-checking bench for ntt_bram_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ntt_bram_arbiter;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [12:0] m0_addr = '0;
  logic [63:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [12:0] m1_addr = '0;
  logic [63:0] m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic [12:0] BRAM_addr;
  logic        BRAM_clk, BRAM_en, BRAM_we, busy;
  logic [63:0] BRAM_din;
  logic [63:0] BRAM_dout = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_bram_arbiter #(.AW(13), .DW(64), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .BRAM_addr(BRAM_addr), .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .BRAM_en(BRAM_en), .BRAM_we(BRAM_we), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [12:0] a);
    return {32'hDEADBEEF, 19'd0, a};
  endfunction

  // BRAM model: unwritten words read as dflt(addr); data valid RD_LAT cycles after the en cycle.
  logic [63:0] bmem [int];
  logic        hv [0:RD_LAT];
  logic [63:0] hd [0:RD_LAT];
  initial for (int i = 0; i <= RD_LAT; i++) begin hv[i] = 1'b0; hd[i] = '0; end

  always @(negedge clk) begin
    for (int i = RD_LAT; i > 0; i--) begin hv[i] = hv[i-1]; hd[i] = hd[i-1]; end
    hv[0] = 1'b0;
    hd[0] = '0;
    if (BRAM_en === 1'b1) begin
      if (BRAM_we === 1'b1) bmem[int'(BRAM_addr)] = BRAM_din;
      else begin
        hv[0] = 1'b1;
        hd[0] = bmem.exists(int'(BRAM_addr)) ? bmem[int'(BRAM_addr)] : dflt(BRAM_addr);
      end
    end
    BRAM_dout = (hv[RD_LAT] === 1'b1) ? hd[RD_LAT] : {$urandom, $urandom};
  end

  // Transaction-level reference: accepted requests, expected returns keyed by cycle.
  bit          m_started = 1'b0;
  logic        m_last, m_acc_prev, exp_en, exp_we;
  logic [12:0] exp_addr;
  logic [63:0] exp_din, exp_rd0, exp_rd1;
  logic [63:0] due0 [int];
  logic [63:0] due1 [int];
  logic [63:0] shadow [int];
  int          rd_acc [$];

  always @(negedge clk) begin : model_p
    logic g_any, g_port, lock_hold, rv0_e, rv1_e, s_we;
    logic [12:0] s_addr;
    logic [63:0] s_data, rv_data;
    if (rst === 1'b1) begin
      if (m_started) begin
        chk("m0_gnt_in_reset", m0_gnt, 0);
        chk("m1_gnt_in_reset", m1_gnt, 0);
      end
      m_started = 1'b1;
      m_last = 1'b1; m_acc_prev = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
      exp_addr = '0; exp_din = '0; exp_rd0 = '0; exp_rd1 = '0;
      due0.delete(); due1.delete(); rd_acc.delete();
    end else if (m_started) begin
      lock_hold = 1'b0;
`ifdef ARB_LOCK_EN
      lock_hold = m_acc_prev && (m_last ? (m1_req && m1_lock) : (m0_req && m0_lock));
`endif
      g_any = m0_req || m1_req;
      if (lock_hold) g_port = m_last;
      else if (m0_req && m1_req) g_port = !m_last;
      else g_port = m1_req;
      chk("m0_gnt", m0_gnt, g_any && !g_port);
      chk("m1_gnt", m1_gnt, g_any && g_port);
      chk("BRAM_en", BRAM_en, exp_en);
      chk("BRAM_we", BRAM_we, exp_we);
      chk("BRAM_addr", BRAM_addr, exp_addr);
      chk("BRAM_din", BRAM_din, exp_din);
      rv0_e = due0.exists(cyc);
      if (rv0_e) begin exp_rd0 = due0[cyc]; due0.delete(cyc); end
      rv1_e = due1.exists(cyc);
      if (rv1_e) begin exp_rd1 = due1[cyc]; due1.delete(cyc); end
      chk("m0_rvalid", m0_rvalid, rv0_e);
      chk("m1_rvalid", m1_rvalid, rv1_e);
      chk("m0_rdata", m0_rdata, exp_rd0);
      chk("m1_rdata", m1_rdata, exp_rd1);
      while (rd_acc.size() > 0 && rd_acc[0] + RD_LAT + 2 < cyc) void'(rd_acc.pop_front());
      chk("busy", busy, rd_acc.size() > 0);
      if (g_any) begin
        s_we   = g_port ? m1_we : m0_we;
        s_addr = g_port ? m1_addr : m0_addr;
        s_data = g_port ? m1_wdata : m0_wdata;
        m_last = g_port; exp_en = 1'b1; exp_we = s_we; exp_addr = s_addr; exp_din = s_data;
        if (s_we) shadow[int'(s_addr)] = s_data;
        else begin
          rv_data = shadow.exists(int'(s_addr)) ? shadow[int'(s_addr)] : dflt(s_addr);
          if (g_port) due1[cyc + RD_LAT + 2] = rv_data;
          else due0[cyc + RD_LAT + 2] = rv_data;
          rd_acc.push_back(cyc);
        end
      end else begin
        exp_en = 1'b0; exp_we = 1'b0;
      end
      m_acc_prev = g_any;
    end
  end

  // Return/strobe log for the directed scenarios.
  bit          rv_port [$];
  logic [63:0] rv_data_q [$];
  int          rv_cyc [$];
  logic        busy_log [int];
  int          en_cnt = 0;

  always @(negedge clk) begin
    if (m0_rvalid === 1'b1) begin rv_port.push_back(1'b0); rv_data_q.push_back(m0_rdata); rv_cyc.push_back(cyc); end
    if (m1_rvalid === 1'b1) begin rv_port.push_back(1'b1); rv_data_q.push_back(m1_rdata); rv_cyc.push_back(cyc); end
    if (BRAM_en === 1'b1) en_cnt++;
    busy_log[cyc] = busy;
  end

  task automatic clear_log();
    rv_port.delete(); rv_data_q.delete(); rv_cyc.delete(); busy_log.delete(); en_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [12:0] a0, input logic [63:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [12:0] a1, input logic [63:0] d1, input logic l1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_lock = l0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
  endtask

  task automatic idle();
    drive(0, 0, 13'h0, 64'h0, 0, 0, 0, 13'h0, 64'h0, 0);
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic reset_pulse();
    tick(); rst = 1'b1; idle();
    tick(); rst = 1'b0;
  endtask

  int          acc_c, last_c;
  logic        g;
  logic [5:0]  gseq, rseq;
  logic [8:0]  lseq, lseq_exp;
  logic [12:0] a0, a1;
  logic        rq [2], rw [2], rl [2];
  logic [12:0] ra [2];
  logic [63:0] rdw [2];
  bit          acc [2];

  initial begin
    idle();
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    idle_n(2);

    // Single read from port 1.
    clear_log();
    drive(0, 0, 13'h0, 64'h0, 0, 1, 0, 13'h0040, 64'h0, 0);
    #1; chk("t1_gnt", m1_gnt, 1); acc_c = cyc;
    tick(); idle_n(10);
    chk("t1_returns", rv_port.size(), 1);
    if (rv_port.size() == 1) begin
      chk("t1_port", rv_port[0], 1);
      chk("t1_latency", rv_cyc[0] - acc_c, RD_LAT + 2);
      chk("t1_data", rv_data_q[0], 64'hDEADBEEF_00000040);
    end

    // Write from port 0, read back from port 1.
    clear_log();
    drive(1, 1, 13'h1040, 64'h1234, 0, 0, 0, 13'h0, 64'h0, 0);
    #1; chk("t3_wr_gnt", m0_gnt, 1);
    tick();
    drive(0, 0, 13'h0, 64'h0, 0, 1, 0, 13'h1040, 64'h0, 0);
    #1; chk("t3_rd_gnt", m1_gnt, 1);
    chk("t3_we", BRAM_we, 1); chk("t3_addr", BRAM_addr, 13'h1040); chk("t3_din", BRAM_din, 64'h1234);
    tick(); idle(); #1;
    chk("t3_we_one_cycle", BRAM_we, 0);
    idle_n(10);
    chk("t3_returns", rv_port.size(), 1);
    if (rv_port.size() == 1) chk("t3_readback", rv_data_q[0], 64'h1234);

    // Lone read at the top address, then idle.
    tick(); clear_log();
    drive(1, 0, 13'h1FFF, 64'h0, 0, 0, 0, 13'h0, 64'h0, 0);
    #1; chk("t5_gnt", m0_gnt, 1);
    tick(); idle_n(5);
    chk("t5_en_pulses", en_cnt, 1);
    chk("t5_addr_hold", BRAM_addr, 13'h1FFF);
    idle_n(4);

    // Contention from reset: grants and returns alternate starting with port 0.
    reset_pulse(); clear_log();
    a0 = 13'h100; a1 = 13'h200;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, a0, 64'h0, 0, 1, 0, a1, 64'h0, 0);
      #1; gseq[i] = m1_gnt;
      if (m0_gnt) a0++;
      if (m1_gnt) a1++;
      tick();
    end
    idle_n(12);
    chk("t2_grants", gseq, 6'b101010);
    chk("t2_returns", rv_port.size(), 6);
    if (rv_port.size() == 6) begin
      for (int i = 0; i < 6; i++) rseq[i] = rv_port[i];
      chk("t2_return_order", rseq, 6'b101010);
      last_c = rv_cyc[5];
      chk("t2_busy_last", busy_log.exists(last_c) ? busy_log[last_c] : 1'bx, 1);
      chk("t2_busy_after", busy_log.exists(last_c + 1) ? busy_log[last_c + 1] : 1'bx, 0);
    end

    // Reset while two reads are in flight.
    clear_log();
    drive(1, 0, 13'h0010, 64'h0, 0, 1, 0, 13'h0020, 64'h0, 0);
    #1; g = m1_gnt;
    tick();
    if (g) drive(1, 0, 13'h0010, 64'h0, 0, 0, 0, 13'h0, 64'h0, 0);
    else drive(0, 0, 13'h0, 64'h0, 0, 1, 0, 13'h0020, 64'h0, 0);
    #1; chk("t4_second_gnt", g ? m0_gnt : m1_gnt, 1);
    tick(); idle();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t4_en", BRAM_en, 0); chk("t4_we", BRAM_we, 0);
    chk("t4_addr", BRAM_addr, 0); chk("t4_din", BRAM_din, 0);
    chk("t4_rdata0", m0_rdata, 0); chk("t4_rdata1", m1_rdata, 0);
    chk("t4_busy", busy, 0);
    idle_n(8);
    chk("t4_no_returns", rv_port.size(), 0);
    drive(1, 0, 13'h0030, 64'h0, 0, 1, 0, 13'h0031, 64'h0, 0);
    #1; chk("t4_first_gnt_port0", {m1_gnt, m0_gnt}, 2'b01);
    tick(); idle_n(10);

    // Lock request from port 1 with port 0 contending.
    reset_pulse();
    for (int i = 0; i < 9; i++) begin
      drive(i > 0, 0, 13'h0050, 64'h0, 0, 1, 0, 13'h0060, 64'h0, i < 8);
      #1; lseq[i] = m1_gnt;
      tick();
    end
`ifdef ARB_LOCK_EN
    lseq_exp = 9'b0_1111_1111;
`else
    lseq_exp = 9'b1_0101_0101;
`endif
    chk("lock_grants", lseq, lseq_exp);
    idle_n(10);

    // Random traffic with occasional resets.
    clear_log();
    for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; acc[p] = 1'b0; rw[p] = 1'b0; rl[p] = 1'b0; ra[p] = '0; rdw[p] = '0; end
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || acc[p]) begin
          rq[p] = ($urandom_range(0, 3) != 0);
          rw[p] = ($urandom_range(0, 2) == 0);
          case ($urandom_range(0, 3))
            0: ra[p] = 13'h0000;
            1: ra[p] = 13'h1FFF;
            2: ra[p] = 13'($urandom_range(0, 7));
            default: ra[p] = 13'($urandom);
          endcase
          rdw[p] = {$urandom, $urandom};
        end
        rl[p] = ($urandom_range(0, 3) != 0);
      end
      drive(rq[0], rw[0], ra[0], rdw[0], rl[0], rq[1], rw[1], ra[1], rdw[1], rl[1]);
      #1;
      acc[0] = rq[0] && m0_gnt;
      acc[1] = rq[1] && m1_gnt;
    end
    rst = 1'b0;
    idle_n(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
